// File: rtl/core_pkg.sv
// Shared fetch-stage types and constants for the RV32 core.
package core_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR_ENC = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP       = 32'd4;

    typedef enum logic [2:0] {BOOT, REQ, WAIT, KILL, HOLD} fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/pc_fetch_ctrl_pc.sv
// Architectural PC register with load enable; the next value is chosen by the caller.
module pc
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  q <= RESET_VECTOR;
        else if (en) q <= d;
    end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: PC selection, single-outstanding imem handshake, IF/ID presentation.
module pc_fetch_ctrl
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR    = NOP_INSTR_ENC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_instr_o,
    output logic            flush_o,
    output logic [XLEN-1:0] pc_o
);
    fetch_state_t    state;
    logic [XLEN-1:0] pc_q, pc_d, target, hold_pc, hold_instr;
    logic            pc_en, redirect;

    assign redirect = trap_i | br_taken_i;
    assign target   = word_align(trap_i ? trap_vec_i : br_target_i);

    always_comb begin
        pc_en = 1'b0;
        pc_d  = pc_q + PC_STEP;
        if (redirect) begin
            pc_en = 1'b1;
            pc_d  = target;
        end else begin
            case (state)
                WAIT:    pc_en = imem_rvalid_i & ~stall_i;
                HOLD:    pc_en = ~stall_i;
                default: pc_en = 1'b0;
            endcase
        end
    end

    pc #(.RESET_VECTOR(RESET_VECTOR)) u_pc (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .d     (pc_d),
        .q     (pc_q)
    );

    // A stale rvalid in KILL always ends the kill, even if another redirect lands that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BOOT;
            hold_pc    <= '0;
            hold_instr <= NOP_INSTR;
        end else begin
            case (state)
                BOOT: state <= REQ;
                REQ:  if (imem_gnt_i) state <= redirect ? KILL : WAIT;
                WAIT: begin
                    if (redirect) begin
                        state <= imem_rvalid_i ? REQ : KILL;
                    end else if (imem_rvalid_i) begin
                        state <= stall_i ? HOLD : REQ;
                        if (stall_i) begin
                            hold_pc    <= pc_q;
                            hold_instr <= imem_rdata_i;
                        end
                    end
                end
                KILL: if (imem_rvalid_i) state <= REQ;
                HOLD: if (redirect || !stall_i) state <= REQ;
                default: state <= BOOT;
            endcase
        end
    end

    assign imem_req_o  = (state == REQ);
    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign flush_o     = redirect & reset;

    // Instruction is offered as soon as it returns; stall only decides whether it is parked in HOLD.
    always_comb begin
        if_valid_o = 1'b0;
        if_pc_o    = '0;
        if_instr_o = NOP_INSTR;
        if (!redirect) begin
            case (state)
                WAIT: if (imem_rvalid_i) begin
                    if_valid_o = 1'b1;
                    if_pc_o    = pc_q;
                    if_instr_o = imem_rdata_i;
                end
                HOLD: begin
                    if_valid_o = 1'b1;
                    if_pc_o    = hold_pc;
                    if_instr_o = hold_instr;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed vector bench for pc_fetch_ctrl plus an async-reset-mid-fetch sequence.
module tb_pc_fetch_ctrl;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] J   = 32'hBAD0_BAD0;

    logic        clk = 1'b0, reset = 1'b0;
    logic        stall_i = 0, br_taken_i = 0, trap_i = 0;
    logic [31:0] br_target_i = 0, trap_vec_i = 0;
    logic        imem_req_o, imem_gnt_i = 0, imem_rvalid_i = 0;
    logic [31:0] imem_addr_o, imem_rdata_i = 0;
    logic        if_valid_o, flush_o;
    logic [31:0] if_pc_o, if_instr_o, pc_o;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .br_taken_i(br_taken_i),
        .br_target_i(br_target_i), .trap_i(trap_i), .trap_vec_i(trap_vec_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_instr_o(if_instr_o),
        .flush_o(flush_o), .pc_o(pc_o)
    );

    typedef struct {
        logic        stall, br;
        logic [31:0] bt;
        logic        trap;
        logic [31:0] tv;
        logic        gnt, rv;
        logic [31:0] rd;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ipc, ins;
        logic        fl;
    } vec_t;

    vec_t vt[28];

    function automatic vec_t mk(logic stall, logic br, logic [31:0] bt, logic trap,
                                logic [31:0] tv, logic gnt, logic rv, logic [31:0] rd,
                                logic req, logic [31:0] addr, logic vld,
                                logic [31:0] ipc, logic [31:0] ins, logic fl);
        vec_t v;
        v.stall = stall; v.br = br; v.bt = bt; v.trap = trap; v.tv = tv;
        v.gnt = gnt; v.rv = rv; v.rd = rd;
        v.req = req; v.addr = addr; v.vld = vld; v.ipc = ipc; v.ins = ins; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall_i = v.stall; br_taken_i = v.br; br_target_i = v.bt;
        trap_i = v.trap; trap_vec_i = v.tv;
        imem_gnt_i = v.gnt; imem_rvalid_i = v.rv; imem_rdata_i = v.rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        //                 stl br bt            tp tv       gnt rv rd               req addr          vld ipc           ins              fl
        vt[0]  = mk(0, 0, 0,            0, 0,       0, 0, 0,              0, 32'h0,        0, 0,            NOP,             0);
        vt[1]  = mk(0, 0, 0,            0, 0,       1, 0, 0,              1, 32'h0,        0, 0,            NOP,             0);
        vt[2]  = mk(0, 0, 0,            0, 0,       0, 1, 32'h1111_0000,  0, 32'h0,        1, 32'h0,        32'h1111_0000,   0);
        vt[3]  = mk(0, 0, 0,            0, 0,       1, 0, 0,              1, 32'h4,        0, 0,            NOP,             0);
        vt[4]  = mk(0, 0, 0,            0, 0,       0, 1, 32'h1111_0004,  0, 32'h4,        1, 32'h4,        32'h1111_0004,   0);
        vt[5]  = mk(0, 0, 0,            0, 0,       1, 0, 0,              1, 32'h8,        0, 0,            NOP,             0);
        vt[6]  = mk(0, 0, 0,            0, 0,       0, 1, 32'h1111_0008,  0, 32'h8,        1, 32'h8,        32'h1111_0008,   0);
        vt[7]  = mk(0, 0, 0,            0, 0,       1, 0, 0,              1, 32'hC,        0, 0,            NOP,             0);
        vt[8]  = mk(0, 0, 0,            0, 0,       0, 1, 32'h1111_000C,  0, 32'hC,        1, 32'hC,        32'h1111_000C,   0);
        vt[9]  = mk(0, 0, 0,            0, 0,       1, 0, 0,              1, 32'h10,       0, 0,            NOP,             0);
        // branch in WAIT, then the stale response must be swallowed in KILL
        vt[10] = mk(0, 1, 32'h42,       0, 0,       0, 0, 0,              0, 32'h10,       0, 0,            NOP,             1);
        vt[11] = mk(0, 0, 0,            0, 0,       0, 0, 0,              0, 32'h40,       0, 0,            NOP,             0);
        vt[12] = mk(0, 0, 0,            0, 0,       0, 1, J,              0, 32'h40,       0, 0,            NOP,             0);
        vt[13] = mk(0, 0, 0,            0, 0,       1, 0, 0,              1, 32'h40,       0, 0,            NOP,             0);
        // trap and branch together: trap target wins
        vt[14] = mk(0, 1, 32'h200,      1, 32'h100, 0, 0, 0,              0, 32'h40,       0, 0,            NOP,             1);
        vt[15] = mk(0, 0, 0,            0, 0,       0, 1, J,              0, 32'h100,      0, 0,            NOP,             0);
        vt[16] = mk(0, 0, 0,            0, 0,       1, 0, 0,              1, 32'h100,      0, 0,            NOP,             0);
        // response under a 3-cycle stall, held until stall drops
        vt[17] = mk(1, 0, 0,            0, 0,       0, 1, 32'h2222_0100,  0, 32'h100,      1, 32'h100,      32'h2222_0100,   0);
        vt[18] = mk(1, 0, 0,            0, 0,       0, 0, 0,              0, 32'h100,      1, 32'h100,      32'h2222_0100,   0);
        vt[19] = mk(1, 0, 0,            0, 0,       0, 0, 0,              0, 32'h100,      1, 32'h100,      32'h2222_0100,   0);
        vt[20] = mk(0, 0, 0,            0, 0,       0, 0, 0,              0, 32'h100,      1, 32'h100,      32'h2222_0100,   0);
        vt[21] = mk(0, 0, 0,            0, 0,       0, 0, 0,              1, 32'h104,      0, 0,            NOP,             0);
        // redirect while REQ not granted, to an unaligned top-of-memory target
        vt[22] = mk(0, 1, 32'hFFFF_FFFF,0, 0,       0, 0, 0,              1, 32'h104,      0, 0,            NOP,             1);
        vt[23] = mk(0, 0, 0,            0, 0,       1, 0, 0,              1, 32'hFFFF_FFFC,0, 0,            NOP,             0);
        vt[24] = mk(0, 0, 0,            0, 0,       0, 1, 32'h3333_FFFC,  0, 32'hFFFF_FFFC,1, 32'hFFFF_FFFC,32'h3333_FFFC,   0);
        vt[25] = mk(0, 0, 0,            0, 0,       1, 0, 0,              1, 32'h0,        0, 0,            NOP,             0);
        // redirect coinciding with rvalid under stall: data dropped, straight back to REQ
        vt[26] = mk(1, 1, 32'h80,       0, 0,       0, 1, J,              0, 32'h0,        0, 0,            NOP,             1);
        vt[27] = mk(0, 0, 0,            0, 0,       0, 0, 0,              1, 32'h80,       0, 0,            NOP,             0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset pc_o", pc_o, 32'h0);
        chk("reset req", {31'b0, imem_req_o}, 32'h0);
        chk("reset valid", {31'b0, if_valid_o}, 32'h0);
        chk("reset if_pc", if_pc_o, 32'h0);
        chk("reset instr", if_instr_o, NOP);
        chk("reset flush", {31'b0, flush_o}, 32'h0);

        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 28; i++) begin
            drive(vt[i]);
            @(negedge clk);
            chk($sformatf("v%0d req", i),   {31'b0, imem_req_o}, {31'b0, vt[i].req});
            chk($sformatf("v%0d addr", i),  imem_addr_o, vt[i].addr);
            chk($sformatf("v%0d pc_o", i),  pc_o, vt[i].addr);
            chk($sformatf("v%0d valid", i), {31'b0, if_valid_o}, {31'b0, vt[i].vld});
            chk($sformatf("v%0d if_pc", i), if_pc_o, vt[i].ipc);
            chk($sformatf("v%0d instr", i), if_instr_o, vt[i].ins);
            chk($sformatf("v%0d flush", i), {31'b0, flush_o}, {31'b0, vt[i].fl});
            @(posedge clk); #1;
        end

        // grant at 0x80, then assert reset in the middle of WAIT
        drive(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        imem_gnt_i = 1'b0;
        #2;
        chk("wait pc_o", pc_o, 32'h80);
        chk("wait req", {31'b0, imem_req_o}, 32'h0);
        reset = 1'b0;
        #1;
        chk("async pc_o", pc_o, 32'h0);
        chk("async req", {31'b0, imem_req_o}, 32'h0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = J;
        #1;
        chk("rst rvalid ignored", {31'b0, if_valid_o}, 32'h0);
        chk("rst instr", if_instr_o, NOP);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("boot rvalid ignored", {31'b0, if_valid_o}, 32'h0);
        chk("boot req", {31'b0, imem_req_o}, 32'h0);
        @(posedge clk); #1;
        imem_rvalid_i = 1'b0;
        imem_gnt_i    = 1'b1;
        @(negedge clk);
        chk("restart req", {31'b0, imem_req_o}, 32'h1);
        chk("restart addr", imem_addr_o, 32'h0);
        @(posedge clk); #1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h4444_0000;
        @(negedge clk);
        chk("restart valid", {31'b0, if_valid_o}, 32'h1);
        chk("restart if_pc", if_pc_o, 32'h0);
        chk("restart instr", if_instr_o, 32'h4444_0000);
        @(posedge clk); #1;
        imem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("restart next addr", imem_addr_o, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
